// File: rtl/riscv_pkg.sv
// Shared RV32M encodings and state types for the iterative multiply/divide unit.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_operand_prep.sv
// Operand conditioning: per-op signedness, magnitudes, result sign flags and
// the divide special cases that bypass iteration entirely.
module muldiv_operand_prep #(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic [XLEN-1:0] mag_a,
  output logic [XLEN-1:0] mag_b,
  output logic            neg_res,
  output logic            neg_rem,
  output logic            special,
  output logic [XLEN-1:0] special_res
);
  import riscv_pkg::*;

  muldiv_op_e op;
  logic       a_signed;
  logic       b_signed;
  logic       a_neg;
  logic       b_neg;
  logic       div_zero;
  logic       overflow;

  always_comb begin
    op       = muldiv_op_e'(funct3);
    a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg    = a_signed && operand_a[XLEN-1];
    b_neg    = b_signed && operand_b[XLEN-1];
    // The most negative value negates to itself, which is still the correct unsigned magnitude.
    mag_a    = a_neg ? (~operand_a + 1'b1) : operand_a;
    mag_b    = b_neg ? (~operand_b + 1'b1) : operand_b;
    neg_res  = a_neg ^ b_neg;
    neg_rem  = a_neg;

    div_zero = funct3[2] && (operand_b == '0);
    overflow = ((op == OP_DIV) || (op == OP_REM)) &&
               (operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (operand_b == '1);
    special  = div_zero || overflow;

    special_res = '0;
    if (div_zero) begin
      special_res = funct3[1] ? operand_a : '1;
    end else if (overflow) begin
      special_res = funct3[1] ? '0 : operand_a;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32 shift-add or restoring-divide steps,
// one sign-fix cycle, then a one-cycle done pulse.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  import riscv_pkg::*;

  localparam int CNT_W = $clog2(XLEN);

  muldiv_state_e     state, state_next;
  logic [CNT_W-1:0]  count;
  muldiv_op_e        op_q;
  logic              neg_res_q;
  logic              neg_rem_q;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] mcand;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   divisor;
  logic [XLEN-1:0]   rem;

  logic [XLEN-1:0]   mag_a, mag_b, special_res, fix_res;
  logic              neg_res, neg_rem, special, accept;
  logic [XLEN:0]     rem_shift, rem_diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  muldiv_operand_prep #(.XLEN(XLEN)) u_prep (
    .funct3      (funct3_i),
    .operand_a   (operand_a_i),
    .operand_b   (operand_b_i),
    .mag_a       (mag_a),
    .mag_b       (mag_b),
    .neg_res     (neg_res),
    .neg_rem     (neg_rem),
    .special     (special),
    .special_res (special_res)
  );

  assign accept = start_i && ((state == IDLE) || (state == DONE));

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start_i)           state_next = special ? DONE : CALC;
        else if (state == DONE) state_next = IDLE;
      end
      CALC:    if (count == CNT_W'(XLEN-1)) state_next = FIX;
      FIX:     state_next = DONE;
      default: state_next = IDLE;
    endcase
    busy_o = (state == CALC) || (state == FIX);
    done_o = (state == DONE);
  end

  always_comb begin
    rem_shift = {rem, quo[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, divisor};
    prod_fix  = neg_res_q ? (~acc + 1'b1) : acc;
    quo_fix   = neg_res_q ? (~quo + 1'b1) : quo;
    rem_fix   = neg_rem_q ? (~rem + 1'b1) : rem;
    fix_res   = '0;
    case (op_q)
      OP_MUL:                        fix_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               fix_res = quo_fix;
      default:                       fix_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= IDLE;
      count    <= '0;
      result_o <= '0;
    end else begin
      state <= state_next;
      if (accept)              count <= '0;
      else if (state == CALC)  count <= count + 1'b1;
      if (accept && special)   result_o <= special_res;
      else if (state == FIX)   result_o <= fix_res;
    end
  end

  // quo holds the multiplier (shifting out LSB-first) or the dividend turning into the quotient.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      op_q      <= muldiv_op_e'(funct3_i);
      neg_res_q <= neg_res;
      neg_rem_q <= neg_rem;
      acc       <= '0;
      mcand     <= {{XLEN{1'b0}}, mag_a};
      quo       <= funct3_i[2] ? mag_a : mag_b;
      divisor   <= mag_b;
      rem       <= '0;
    end else if (state == CALC) begin
      if (op_q[2]) begin
        if (!rem_diff[XLEN]) begin
          rem <= rem_diff[XLEN-1:0];
          quo <= {quo[XLEN-2:0], 1'b1};
        end else begin
          rem <= rem_shift[XLEN-1:0];
          quo <= {quo[XLEN-2:0], 1'b0};
        end
      end else begin
        if (quo[0]) acc <= acc + mcand;
        mcand <= mcand << 1;
        quo   <= quo >> 1;
      end
    end
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit. Sits beside the ALU in the execute stage and is fed from decode with the same funct3/funct7 fields the ALU controller consumes.
- Selected when opcode is OP and funct7 = 7'b0000001. While busy, the core stalls PC/regfile write.
- Returns one 32-bit result per accepted operation via a start/done handshake.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk_i  input  1  clock, rising edge
- rst_ni  input  1  reset, synchronous, active-low
- start_i  input  1  request; accepted only in IDLE or DONE
- funct3_i  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- operand_a_i  input  XLEN  rs1 value, sampled on accept
- operand_b_i  input  XLEN  rs2 value, sampled on accept
- busy_o  output  1  high while an accepted op is in progress; core stall
- done_o  output  1  one-cycle pulse; result_o valid
- result_o  output  XLEN  result, held until next accept or reset

Behaviour:
- Reset (rst_ni=0 at clk edge): state=IDLE, busy_o=0, done_o=0, result_o=0, counter=0. Reset mid-operation abandons the op with no done_o.
- States: IDLE, CALC, FIX, DONE.
- Accept in cycle N (start_i=1 in IDLE/DONE):
  - Latch funct3, operands, magnitudes and signs.
  - Signedness: MULH and DIV/REM treat both operands as signed. MULHSU treats a as signed, b as unsigned. MUL, MULHU, DIVU, REMU treat both as unsigned magnitudes; MUL low word is sign-agnostic.
- Normal path:
  - IDLE→CALC at end of N; counter=0.
  - CALC: N+1..N+32, one iteration per cycle, counter+1.
    - Multiply: shift-add into a 64-bit product.
    - Divide: restoring, one quotient bit per cycle, 33-bit partial remainder.
  - counter==XLEN-1 → FIX.
  - FIX (N+33): apply sign correction.
    - Product is negated if signs differ.
    - Quotient is negated if signs differ.
    - Remainder takes the dividend's sign.
    - Select the result: MUL low 32; MULH/MULHSU/MULHU high 32; DIV/DIVU quotient; REM/REMU remainder. Register it into result_o.
    - Then → DONE.
  - DONE (N+34): done_o=1, busy_o=0. Next state is IDLE, or CALC if start_i=1.
- busy_o=1 exactly in CALC and FIX (N+1..N+33). Latency from accept to done_o is 34 cycles.
- Special cases, resolved in IDLE/DONE with no iterations (IDLE→DONE, done_o at N+1, busy_o never asserted):
  - Divide by zero, any div/rem: DIV/DIVU → 32'hFFFFFFFF; REM/REMU → operand_a.
  - Signed overflow: DIV/REM with a=32'h80000000, b=32'hFFFFFFFF → DIV gives 32'h80000000, REM gives 0.
- start_i in CALC/FIX is ignored: no queueing, latched operands unchanged. Operand changes after accept have no effect.
- All arithmetic is modulo 2^64 internally; results are truncated to XLEN. No exceptions are raised.

Decomposition:
- riscv_pkg:
  - muldiv_op_e enum mapping the funct3 encodings.
  - FUNCT7_MULDIV = 7'b0000001.
  - muldiv_state_e enum {IDLE, CALC, FIX, DONE}.
  - XLEN constant.
- One natural sub-module, muldiv_operand_prep (combinational): per-op signedness, absolute values, result-sign flags, div-by-zero and overflow detection.
- Datapath and FSM stay in muldiv_unit.

Test Plan:
- MUL a=7, b=32'hFFFFFFFD (-3) → result 32'hFFFFFFEB; done_o exactly 34 cycles after accept; busy_o high 33 cycles.
- MULHU a=b=32'hFFFFFFFF → 32'hFFFFFFFE. MULH same operands → 0. MULHSU a=32'hFFFFFFFF, b=32'hFFFFFFFF → 32'hFFFFFFFF.
- DIV a=-7, b=2 → 32'hFFFFFFFD. REM same operands → 32'hFFFFFFFF. DIVU a=100, b=7 → 14. REMU same operands → 2.
- DIVU a=123, b=0 → 32'hFFFFFFFF with done_o at N+1 and busy_o never high. REM a=32'h80000000, b=32'hFFFFFFFF → 0, also at N+1.
- Back-to-back: start_i held during DONE of op1 → op2 accepted that cycle; start_i pulses during CALC are ignored with result unchanged; operands changed mid-CALC do not affect result.
- rst_ni low at cycle 10 of a DIV → next cycle IDLE, result_o=0, busy_o=0, no done_o. A fresh MUL 3*4 then returns 12.
